// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the case converter datapath.
//   - case-transform mode encoding
//   - ASCII letter bounds and the upper/lower case offset
//   - sequencer state encoding
package uart_pkg;

  // Case-transform mode encoding (i_mode)
  localparam logic [1:0] MODE_PASS   = 2'b00;
  localparam logic [1:0] MODE_UPPER  = 2'b01;
  localparam logic [1:0] MODE_LOWER  = 2'b10;
  localparam logic [1:0] MODE_TOGGLE = 2'b11;

  // ASCII letter ranges and the distance between the two cases
  localparam logic [7:0] ASCII_UPPER_LO = 8'h41; // 'A'
  localparam logic [7:0] ASCII_UPPER_HI = 8'h5A; // 'Z'
  localparam logic [7:0] ASCII_LOWER_LO = 8'h61; // 'a'
  localparam logic [7:0] ASCII_LOWER_HI = 8'h7A; // 'z'
  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

  // Sequencer state encoding
  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_POP_ENC  = 2'd1;
  localparam logic [1:0] ST_WAIT_ENC = 2'd2;
  localparam logic [1:0] ST_PUSH_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_POP  = ST_POP_ENC,
    ST_WAIT = ST_WAIT_ENC,
    ST_PUSH = ST_PUSH_ENC
  } state_t;

endpackage

// File: rtl/ascii_case_conv.sv
// ascii_case_conv: combinational ASCII case transform.
// Ports:
//   data    in  8  input byte
//   mode    in  2  transform select (pass / upper / lower / toggle)
//   result  out 8  transformed byte
//   changed out 1  result differs from data
// Bytes outside A-Z / a-z (including 0x80..0xFF) are never altered.
module ascii_case_conv
  import uart_pkg::*;
(
  input  logic [7:0] data,
  input  logic [1:0] mode,
  output logic [7:0] result,
  output logic       changed
);

  logic is_upper;
  logic is_lower;

  assign is_upper = (data >= ASCII_UPPER_LO) && (data <= ASCII_UPPER_HI);
  assign is_lower = (data >= ASCII_LOWER_LO) && (data <= ASCII_LOWER_HI);

  always_comb begin
    result = data;
    unique case (mode)
      MODE_UPPER: begin
        if (is_lower) result = data - ASCII_CASE_OFS;
      end
      MODE_LOWER: begin
        if (is_upper) result = data + ASCII_CASE_OFS;
      end
      MODE_TOGGLE: begin
        if (is_lower)      result = data - ASCII_CASE_OFS;
        else if (is_upper) result = data + ASCII_CASE_OFS;
      end
      default: result = data;
    endcase
  end

  assign changed = (result != data);

endmodule

// File: rtl/case_conv_ctrl.sv
// case_conv_ctrl: sequencer moving bytes from the RX FIFO through the ASCII
// case transform into the TX FIFO, one byte in flight at a time.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_enable              allow new transfers (current byte always completes)
//   i_mode                transform select, sampled when a byte is popped
//   o_rx_rd_en            RX FIFO read strobe (one cycle per byte)
//   i_rx_rd_data/_valid   RX FIFO read data, valid one cycle after rd_en
//   i_rx_empty            RX FIFO empty
//   o_tx_wr_en/_wr_data   TX FIFO write strobe and data
//   i_tx_full             TX FIFO full (stalls the write)
//   i_tx_almostfull       TX FIFO almost full (blocks starting a new byte)
//   o_busy                not idle
//   o_char_count          bytes written to TX (saturating)
//   o_conv_count          written bytes altered by the transform (saturating)
//   o_err_nodata          sticky: read data missing after a read strobe
//
// Handshake: a read is a one-cycle o_rx_rd_en pulse in POP; the FIFO answers
// with i_rx_rd_valid in the following (WAIT) cycle or the byte is abandoned.
// A write happens in every PUSH cycle where i_tx_full is low; the data is held
// stable for the whole PUSH visit, so stalls never corrupt the byte.
module case_conv_ctrl
  import uart_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic [1:0]           i_mode,
  output logic                 o_rx_rd_en,
  input  logic [7:0]           i_rx_rd_data,
  input  logic                 i_rx_rd_valid,
  input  logic                 i_rx_empty,
  output logic                 o_tx_wr_en,
  output logic [7:0]           o_tx_wr_data,
  input  logic                 i_tx_full,
  input  logic                 i_tx_almostfull,
  output logic                 o_busy,
  output logic [CNT_WIDTH-1:0] o_char_count,
  output logic [CNT_WIDTH-1:0] o_conv_count,
  output logic                 o_err_nodata
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t               state;
  state_t               state_next;
  logic [1:0]           mode_q;
  logic [7:0]           hold;
  logic                 changed_q;
  logic [CNT_WIDTH-1:0] char_count;
  logic [CNT_WIDTH-1:0] conv_count;
  logic                 err_nodata;

  logic [7:0]           conv_result;
  logic                 conv_changed;
  logic                 start_ok;
  logic                 write_now;

  ascii_case_conv u_conv (
    .data    (i_rx_rd_data),
    .mode    (mode_q),
    .result  (conv_result),
    .changed (conv_changed)
  );

  // Almost-full is only consulted here, before a new byte is committed.
  assign start_ok  = i_enable && !i_rx_empty && !i_tx_almostfull;
  assign write_now = (state == ST_PUSH) && !i_tx_full;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      mode_q     <= MODE_PASS;
      hold       <= 8'h00;
      changed_q  <= 1'b0;
      char_count <= '0;
      conv_count <= '0;
      err_nodata <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_POP) mode_q <= i_mode;
      if (state == ST_WAIT) begin
        if (i_rx_rd_valid) begin
          hold      <= conv_result;
          changed_q <= conv_changed;
        end else begin
          err_nodata <= 1'b1;
        end
      end
      if (write_now) begin
        if (char_count != CNT_MAX) char_count <= char_count + 1'b1;
        if (changed_q && (conv_count != CNT_MAX)) conv_count <= conv_count + 1'b1;
      end
    end
  end

  always_comb begin
    state_next   = state;
    o_rx_rd_en   = 1'b0;
    o_tx_wr_en   = 1'b0;
    o_tx_wr_data = 8'h00;
    unique case (state)
      ST_IDLE: begin
        if (start_ok) state_next = ST_POP;
      end
      ST_POP: begin
        o_rx_rd_en = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        state_next = i_rx_rd_valid ? ST_PUSH : ST_IDLE;
      end
      ST_PUSH: begin
        o_tx_wr_data = hold;
        o_tx_wr_en   = !i_tx_full;
        if (!i_tx_full) state_next = start_ok ? ST_POP : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign o_busy       = (state != ST_IDLE);
  assign o_char_count = char_count;
  assign o_conv_count = conv_count;
  assign o_err_nodata = err_nodata;

endmodule

// File: tb/tb_case_conv_ctrl.sv
// tb_case_conv_ctrl: directed and randomized checks of case_conv_ctrl against
// an RX FIFO model, a TX capture queue and a reference case transform.
module tb_case_conv_ctrl;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          rx_rd_en;
  logic [7:0]    rx_rd_data = 8'h00;
  logic          rx_rd_valid = 1'b0;
  logic          rx_empty = 1'b1;
  logic          tx_wr_en;
  logic [7:0]    tx_wr_data;
  logic          tx_full = 1'b0;
  logic          tx_almostfull = 1'b0;
  logic          busy;
  logic [CW-1:0] char_count;
  logic [CW-1:0] conv_count;
  logic          err_nodata;

  int total = 0;
  int bad = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_got[$];
  logic [7:0] exp_q[$];
  logic [7:0] src_q[$];
  bit         pend = 1'b0;
  logic [7:0] pend_data = 8'h00;
  bit         drop_valid = 1'b0;
  int         exp_char = 0;
  int         exp_conv = 0;

  always #5 clk = ~clk;

  case_conv_ctrl #(.CNT_WIDTH(CW)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_enable        (enable),
    .i_mode          (mode),
    .o_rx_rd_en      (rx_rd_en),
    .i_rx_rd_data    (rx_rd_data),
    .i_rx_rd_valid   (rx_rd_valid),
    .i_rx_empty      (rx_empty),
    .o_tx_wr_en      (tx_wr_en),
    .o_tx_wr_data    (tx_wr_data),
    .i_tx_full       (tx_full),
    .i_tx_almostfull (tx_almostfull),
    .o_busy          (busy),
    .o_char_count    (char_count),
    .o_conv_count    (conv_count),
    .o_err_nodata    (err_nodata)
  );

  // RX FIFO model: a read strobe seen in one cycle yields valid data in the next.
  always @(posedge clk) begin
    #1;
    rx_rd_valid = 1'b0;
    if (pend) begin
      pend = 1'b0;
      if (!drop_valid) begin
        rx_rd_valid = 1'b1;
        rx_rd_data  = pend_data;
      end
    end
    if (rx_rd_en && rx_q.size() > 0) begin
      pend_data = rx_q.pop_front();
      pend      = 1'b1;
    end
    rx_empty = (rx_q.size() == 0);
  end

  // TX capture and strobe exclusivity
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_wr_en) tx_got.push_back(tx_wr_data);
      total++;
      assert (!(rx_rd_en && tx_wr_en)) else begin
        bad++;
        $error("FAIL strobe_overlap: rd_en=%0b wr_en=%0b required not both", rx_rd_en, tx_wr_en);
      end
    end
  end

  // Reference transform: letters only, flip the case bit as the mode asks.
  function automatic logic [7:0] ref_conv(input logic [7:0] b, input logic [1:0] m);
    int  v;
    bit  is_up;
    bit  is_lo;
    v     = int'(b);
    is_up = (v >= 65) && (v <= 90);
    is_lo = (v >= 97) && (v <= 122);
    case (m)
      2'b01:   return is_lo ? 8'(v - 32) : b;
      2'b10:   return is_up ? 8'(v + 32) : b;
      2'b11:   return (is_up || is_lo) ? (b ^ 8'h20) : b;
      default: return b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_rd_en"}, 32'(rx_rd_en), 32'd0);
    check({tag, "_wr_en"}, 32'(tx_wr_en), 32'd0);
    check({tag, "_wdata"}, 32'(tx_wr_data), 32'd0);
    check({tag, "_char"},  32'(char_count), 32'd0);
    check({tag, "_conv"},  32'(conv_count), 32'd0);
    check({tag, "_err"},   32'(err_nodata), 32'd0);
  endtask

  task automatic drain(input bit rnd, input string tag);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 400) begin
      tick();
      n++;
      if (rnd) begin
        tx_full       = ($urandom_range(0, 3) == 0);
        tx_almostfull = ($urandom_range(0, 4) == 0);
      end
      done = (rx_q.size() == 0) && !busy && !pend;
    end
    tx_full       = 1'b0;
    tx_almostfull = 1'b0;
    tick();
    tick();
    check({tag, "_drained"}, 32'(done), 32'd1);
  endtask

  task automatic wait_for_rd(input string tag);
    int n;
    n = 0;
    while (!rx_rd_en && n < 30) begin
      tick();
      n++;
    end
    check({tag, "_rd_seen"}, 32'(rx_rd_en), 32'd1);
  endtask

  // Feed src_q under one mode, then compare TX output and counters to the model.
  task automatic run_batch(input logic [1:0] m, input bit rnd, input string tag);
    mode = m;
    foreach (src_q[i]) begin
      exp_q.push_back(ref_conv(src_q[i], m));
      exp_char++;
      if (ref_conv(src_q[i], m) != src_q[i]) exp_conv++;
      rx_q.push_back(src_q[i]);
    end
    src_q.delete();
    drain(rnd, tag);
    check({tag, "_nwr"}, 32'(tx_got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < tx_got.size(); i++)
      check({tag, "_data"}, 32'(tx_got[i]), 32'(exp_q[i]));
    check({tag, "_char"}, 32'(char_count), 32'(exp_char));
    check({tag, "_conv"}, 32'(conv_count), 32'(exp_conv));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    tx_got.delete();
    exp_q.delete();
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    check_reset_outputs("post_reset");
    enable = 1'b1;

    // Upper: a B 3
    src_q = '{8'h61, 8'h42, 8'h33};
    run_batch(2'b01, 1'b0, "upper");
    check("upper_char_const", 32'(char_count), 32'd3);
    check("upper_conv_const", 32'(conv_count), 32'd1);

    // Toggle: Z z !
    src_q = '{8'h5A, 8'h7A, 8'h21};
    run_batch(2'b11, 1'b0, "toggle");
    check("toggle_conv_const", 32'(conv_count), 32'd3);

    // Stall in PUSH with full TX FIFO
    tx_full = 1'b1;
    mode    = 2'b00;
    rx_q.push_back(8'h41);
    begin
      int n;
      n = 0;
      while (!(busy && tx_wr_data == 8'h41) && n < 20) begin
        tick();
        n++;
      end
    end
    check("stall_reach_push", 32'(tx_wr_data), 32'h41);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_wr_en", 32'(tx_wr_en), 32'd0);
      check("stall_wdata", 32'(tx_wr_data), 32'h41);
    end
    check("stall_no_write", 32'(tx_got.size()), 32'd0);
    exp_char++;
    tx_full = 1'b0;
    drain(1'b0, "stall");
    check("stall_nwr", 32'(tx_got.size()), 32'd1);
    if (tx_got.size() > 0) check("stall_data", 32'(tx_got[0]), 32'h41);
    check("stall_char", 32'(char_count), 32'(exp_char));
    tx_got.delete();

    // Almost-full gating
    tx_almostfull = 1'b1;
    rx_q.push_back(8'h62);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("afull_no_rd", 32'(rx_rd_en), 32'd0);
    end
    tx_almostfull = 1'b0;
    check("afull_rd_still_low", 32'(rx_rd_en), 32'd0);
    tick();
    check("afull_rd_after", 32'(rx_rd_en), 32'd1);
    exp_char++;
    drain(1'b0, "afull");
    check("afull_data", 32'(tx_got.size() > 0 ? tx_got[0] : 8'h00), 32'h62);
    tx_got.delete();

    // Missing read data
    drop_valid = 1'b1;
    mode       = 2'b01;
    rx_q.push_back(8'h61);
    begin
      int n;
      n = 0;
      while (!err_nodata && n < 20) begin
        tick();
        n++;
      end
    end
    drop_valid = 1'b0;
    check("nodata_err", 32'(err_nodata), 32'd1);
    drain(1'b0, "nodata");
    check("nodata_no_write", 32'(tx_got.size()), 32'd0);
    check("nodata_char", 32'(char_count), 32'(exp_char));
    check("nodata_conv", 32'(conv_count), 32'(exp_conv));
    src_q = '{8'h6B};
    run_batch(2'b01, 1'b0, "after_nodata");
    check("nodata_err_sticky", 32'(err_nodata), 32'd1);

    // Mode change after the byte was popped has no effect on it
    mode = 2'b01;
    rx_q.push_back(8'h61);
    wait_for_rd("modechg");
    tick();
    mode = 2'b10;
    exp_char++;
    exp_conv++;
    drain(1'b0, "modechg");
    check("modechg_data", 32'(tx_got.size() > 0 ? tx_got[0] : 8'h00), 32'h41);
    check("modechg_conv", 32'(conv_count), 32'(exp_conv));
    tx_got.delete();

    // Enable dropped mid-transfer: current byte completes, next waits
    mode = 2'b00;
    rx_q.push_back(8'h10);
    rx_q.push_back(8'h20);
    wait_for_rd("enable");
    enable = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("enable_one_write", 32'(tx_got.size()), 32'd1);
    check("enable_left", 32'(rx_q.size()), 32'd1);
    check("enable_idle", 32'(busy), 32'd0);
    enable = 1'b1;
    exp_char += 2;
    drain(1'b0, "enable");
    check("enable_both", 32'(tx_got.size()), 32'd2);
    tx_got.delete();

    // Randomized batches with random flow control
    for (int b = 0; b < 6; b++) begin
      int nb;
      nb = $urandom_range(4, 12);
      for (int k = 0; k < nb; k++) begin
        logic [7:0] v;
        case ($urandom_range(0, 2))
          0:       v = 8'($urandom_range(8'h41, 8'h5A));
          1:       v = 8'($urandom_range(8'h61, 8'h7A));
          default: v = 8'($urandom_range(0, 255));
        endcase
        src_q.push_back(v);
      end
      run_batch(2'($urandom_range(0, 3)), 1'b1, "random");
    end

    // Reset during WAIT
    mode = 2'b01;
    rx_q.push_back(8'h63);
    wait_for_rd("rst_wait");
    tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("rst_wait");
    rst = 1'b0;
    exp_char = 0;
    exp_conv = 0;
    for (int i = 0; i < 6; i++) tick();
    check("rst_wait_no_write", 32'(tx_got.size()), 32'd0);

    // Reset during stalled PUSH
    tx_full = 1'b1;
    rx_q.push_back(8'h41);
    begin
      int n;
      n = 0;
      while (!(busy && tx_wr_data == 8'h41) && n < 20) begin
        tick();
        n++;
      end
    end
    check("rst_push_reached", 32'(tx_wr_data), 32'h41);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("rst_push");
    rst     = 1'b0;
    tx_full = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("rst_push_no_write", 32'(tx_got.size()), 32'd0);
    check("rst_push_char", 32'(char_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
